// File: rtl/sysop_issue.sv
// sysop_issue: issues one SYSTEM instruction at a time to the CSR unit, then writes back and redirects fetch.
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready, in_pc, in_insn, in_rs1_val      decode-side handshake and operands
//   csr_op, csr_tval, csr_wdata, csr_pc                 CSR-unit request (csr_op non-NONE only in ISSUE)
//   csr_rdata, csr_r_valid, csr_trap_en, csr_trap_pc    CSR-unit response, sampled in ISSUE
//   priv                                                current privilege level
//   wb_valid, wb_rd, wb_data                            register writeback pulse
//   redirect_valid, redirect_pc                         fetch redirect/flush pulse
//   busy                                                instruction in flight
// Optional build macro CSR_IMM_EN enables the CSRRWI/CSRRSI/CSRRCI forms.
module sysop_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_insn,
  input  logic [63:0] in_rs1_val,
  output logic [4:0]  csr_op,
  output logic [63:0] csr_tval,
  output logic [63:0] csr_wdata,
  output logic [63:0] csr_pc,
  input  logic [63:0] csr_rdata,
  input  logic        csr_r_valid,
  input  logic        csr_trap_en,
  input  logic [63:0] csr_trap_pc,
  input  logic [1:0]  priv,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
);
  localparam logic [4:0] SYSOP_NONE    = 5'd0;
  localparam logic [4:0] SYSOP_RET     = 5'd4;
  localparam logic [4:0] SYSOP_ILLEGAL = 5'h12;
  localparam logic [4:0] SYSOP_EBREAK  = 5'h13;
  typedef enum logic [1:0] {IDLE, ISSUE, WB, REDIR} state_t;
  state_t state_q, state_d;
  logic [63:0] pc_q, rs1_q, rdata_q, trap_pc_q;
  logic [31:0] insn_q;
  logic        trap_en_q;
  logic [4:0]  dec_op;
  logic [63:0] dec_tval, dec_wdata;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1f;
  logic [11:0] imm12;
  assign f3    = insn_q[14:12];
  assign rd    = insn_q[11:7];
  assign rs1f  = insn_q[19:15];
  assign imm12 = insn_q[31:20];
  // CSR_W/S/C encodings equal funct3[1:0]; ecall cause for U/S/M is {2'b10, priv}.
  always_comb begin
    dec_op    = SYSOP_ILLEGAL;
    dec_tval  = {32'b0, insn_q};
    dec_wdata = '0;
    if (insn_q[6:0] == 7'b1110011) begin
      if (f3 == 3'd0) begin
        if (imm12 == 12'h000) begin
          dec_op   = (priv == 2'd2) ? SYSOP_ILLEGAL : {3'b110, priv};
          dec_tval = (priv == 2'd2) ? {32'b0, insn_q} : '0;
        end else if (imm12 == 12'h001) begin
          dec_op   = SYSOP_EBREAK;
          dec_tval = '0;
        end else if (imm12 == 12'h302 || imm12 == 12'h102) begin
          dec_op   = SYSOP_RET;
          dec_tval = '0;
        end else if (imm12 == 12'h105 || insn_q[31:25] == 7'b0001001) begin
          dec_op   = SYSOP_NONE;
          dec_tval = '0;
        end
      end else if (f3[1:0] != 2'b00 && !f3[2]) begin
        dec_op    = {3'b000, f3[1:0]};
        dec_tval  = {52'b0, imm12};
        dec_wdata = (rs1f == 5'd0) ? '0 : rs1_q;
      end
`ifdef CSR_IMM_EN
      else if (f3[1:0] != 2'b00) begin
        dec_op    = {3'b000, f3[1:0]};
        dec_tval  = {52'b0, imm12};
        dec_wdata = {59'b0, rs1f};
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      insn_q    <= '0;
      rs1_q     <= '0;
      rdata_q   <= '0;
      trap_en_q <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      if (in_valid && in_ready) begin
        pc_q   <= in_pc;
        insn_q <= in_insn;
        rs1_q  <= in_rs1_val;
      end
      if (state_q == ISSUE) begin
        rdata_q   <= csr_rdata;
        trap_en_q <= csr_trap_en;
        trap_pc_q <= csr_trap_pc;
      end
    end
  end
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    csr_op         = SYSOP_NONE;
    csr_tval       = '0;
    csr_wdata      = '0;
    wb_valid       = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        state_d  = in_valid ? ISSUE : IDLE;
      end
      ISSUE: begin
        csr_op    = dec_op;
        csr_tval  = dec_tval;
        csr_wdata = dec_wdata;
        state_d   = (csr_r_valid && rd != 5'd0) ? WB : REDIR;
      end
      WB: begin
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = rdata_q;
        state_d  = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_en_q ? trap_pc_q : pc_q + 64'd4;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy   = !in_ready;
  assign csr_pc = pc_q;
endmodule

// File: tb/tb_sysop_issue.sv
// tb_sysop_issue: directed self-checking bench for sysop_issue.
module tb_sysop_issue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_insn = '0;
  logic [63:0] in_rs1_val = '0;
  logic [4:0]  csr_op;
  logic [63:0] csr_tval, csr_wdata, csr_pc;
  logic [63:0] csr_rdata = '0;
  logic        csr_r_valid = 1'b0;
  logic        csr_trap_en = 1'b0;
  logic [63:0] csr_trap_pc = '0;
  logic [1:0]  priv = 2'd3;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0]  o_op;
  logic [63:0] o_tval, o_wdata, o_pc, o_wdat, o_rpc;
  logic [4:0]  o_rd;
  int n_wb, n_rd, wb_cyc, rd_cyc, extra_op;
  logic o_ready_end;

  sysop_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_insn(in_insn), .in_rs1_val(in_rs1_val),
    .csr_op(csr_op), .csr_tval(csr_tval), .csr_wdata(csr_wdata), .csr_pc(csr_pc),
    .csr_rdata(csr_rdata), .csr_r_valid(csr_r_valid), .csr_trap_en(csr_trap_en),
    .csr_trap_pc(csr_trap_pc), .priv(priv),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Offers one instruction right after a negedge, plays the CSR unit in ISSUE, then observes three cycles.
  task automatic issue_one(input [63:0] pc, input [31:0] insn, input [63:0] rs1,
                           input [63:0] rdata, input rvalid, input ten, input [63:0] tpc);
    in_valid = 1'b1; in_pc = pc; in_insn = insn; in_rs1_val = rs1;
    @(negedge clk);
    in_valid = 1'b0; in_pc = '0; in_insn = '0; in_rs1_val = '0;
    o_op = csr_op; o_tval = csr_tval; o_wdata = csr_wdata; o_pc = csr_pc;
    csr_rdata = rdata; csr_r_valid = rvalid; csr_trap_en = ten; csr_trap_pc = tpc;
    n_wb = 0; n_rd = 0; wb_cyc = -1; rd_cyc = -1; extra_op = 0;
    o_rd = '0; o_wdat = '0; o_rpc = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        csr_rdata = 64'hDEAD_BEEF_DEAD_BEEF; csr_r_valid = 1'b0;
        csr_trap_en = 1'b0; csr_trap_pc = 64'hBAD0;
      end
      if (csr_op !== 5'd0) extra_op++;
      if (wb_valid) begin n_wb++; wb_cyc = c; o_rd = wb_rd; o_wdat = wb_data; end
      if (redirect_valid) begin n_rd++; rd_cyc = c; o_rpc = redirect_pc; end
    end
    o_ready_end = in_ready;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_ready: ready=%b busy=%b want 1/0", in_ready, busy); end
    n_cmp++; if (csr_op !== 5'd0 || wb_valid !== 1'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: op=%0d wb=%b rd=%b want 0", csr_op, wb_valid, redirect_valid); end
    n_cmp++; if (csr_pc !== 64'd0 || csr_tval !== 64'd0 || wb_data !== 64'd0 || redirect_pc !== 64'd0) begin n_bad++; $display("FAIL reset_data: pc=%h tval=%h wbd=%h rpc=%h want 0", csr_pc, csr_tval, wb_data, redirect_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_csrrw;
    issue_one(64'h1000, 32'h300312F3, 64'hA, 64'h1800, 1'b1, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd1 || o_tval !== 64'h300 || o_wdata !== 64'hA || o_pc !== 64'h1000) begin n_bad++; $display("FAIL csrrw_issue: op=%0d tval=%h wdata=%h pc=%h want 1/300/a/1000", o_op, o_tval, o_wdata, o_pc); end
    n_cmp++; if (n_wb !== 1 || wb_cyc !== 0 || o_rd !== 5'd5 || o_wdat !== 64'h1800) begin n_bad++; $display("FAIL csrrw_wb: n=%0d cyc=%0d rd=%0d data=%h want 1/0/5/1800", n_wb, wb_cyc, o_rd, o_wdat); end
    n_cmp++; if (n_rd !== 1 || rd_cyc !== 1 || o_rpc !== 64'h1004 || extra_op !== 0 || o_ready_end !== 1'b1) begin n_bad++; $display("FAIL csrrw_redir: n=%0d cyc=%0d pc=%h extra=%0d rdy=%b want 1/1/1004/0/1", n_rd, rd_cyc, o_rpc, extra_op, o_ready_end); end
  endtask

  task automatic test_ecall;
    priv = 2'd0;
    issue_one(64'h8000_0000, 32'h00000073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100);
    n_cmp++; if (o_op !== 5'd24 || o_tval !== 64'd0) begin n_bad++; $display("FAIL ecall_u_op: op=%0d tval=%h want 24/0", o_op, o_tval); end
    n_cmp++; if (n_wb !== 0 || n_rd !== 1 || rd_cyc !== 0 || o_rpc !== 64'h8000_0100) begin n_bad++; $display("FAIL ecall_u_redir: wb=%0d n=%0d cyc=%0d pc=%h want 0/1/0/80000100", n_wb, n_rd, rd_cyc, o_rpc); end
    priv = 2'd1;
    issue_one(64'h100, 32'h00000073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h200);
    n_cmp++; if (o_op !== 5'd25) begin n_bad++; $display("FAIL ecall_s_op: op=%0d want 25", o_op); end
    priv = 2'd3;
    issue_one(64'h100, 32'h00000073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h200);
    n_cmp++; if (o_op !== 5'd27) begin n_bad++; $display("FAIL ecall_m_op: op=%0d want 27", o_op); end
    priv = 2'd2;
    issue_one(64'h100, 32'h00000073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h200);
    n_cmp++; if (o_op !== 5'd18 || o_tval !== 64'h73) begin n_bad++; $display("FAIL ecall_p2_op: op=%0d tval=%h want 18/73", o_op, o_tval); end
    priv = 2'd3;
  endtask

  task automatic test_system_misc;
    issue_one(64'h300, 32'h00100073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h400);
    n_cmp++; if (o_op !== 5'd19 || o_tval !== 64'd0 || o_rpc !== 64'h400) begin n_bad++; $display("FAIL ebreak: op=%0d tval=%h rpc=%h want 19/0/400", o_op, o_tval, o_rpc); end
    issue_one(64'h300, 32'h30200073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h5550);
    n_cmp++; if (o_op !== 5'd4 || o_rpc !== 64'h5550) begin n_bad++; $display("FAIL mret: op=%0d rpc=%h want 4/5550", o_op, o_rpc); end
    issue_one(64'h300, 32'h10200073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h6660);
    n_cmp++; if (o_op !== 5'd4 || o_rpc !== 64'h6660) begin n_bad++; $display("FAIL sret: op=%0d rpc=%h want 4/6660", o_op, o_rpc); end
    issue_one(64'h300, 32'h10500073, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd0 || n_rd !== 1 || rd_cyc !== 0 || o_rpc !== 64'h304) begin n_bad++; $display("FAIL wfi: op=%0d n=%0d cyc=%0d rpc=%h want 0/1/0/304", o_op, n_rd, rd_cyc, o_rpc); end
    issue_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h12000073, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd0 || o_rpc !== 64'h0 || n_rd !== 1) begin n_bad++; $display("FAIL sfence_wrap: op=%0d rpc=%h n=%0d want 0/0/1", o_op, o_rpc, n_rd); end
  endtask

  task automatic test_illegal;
    issue_one(64'h500, 32'h00000013, 64'h0, 64'h0, 1'b0, 1'b1, 64'h900);
    n_cmp++; if (o_op !== 5'd18 || o_tval !== 64'h13) begin n_bad++; $display("FAIL illegal_opcode: op=%0d tval=%h want 18/13", o_op, o_tval); end
    issue_one(64'h500, 32'h00004073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h900);
    n_cmp++; if (o_op !== 5'd18 || o_tval !== 64'h4073) begin n_bad++; $display("FAIL illegal_f3_4: op=%0d tval=%h want 18/4073", o_op, o_tval); end
    issue_one(64'h500, 32'h00200073, 64'h0, 64'h0, 1'b0, 1'b1, 64'h900);
    n_cmp++; if (o_op !== 5'd18 || o_tval !== 64'h200073 || o_rpc !== 64'h900) begin n_bad++; $display("FAIL illegal_f3_0: op=%0d tval=%h rpc=%h want 18/200073/900", o_op, o_tval, o_rpc); end
  endtask

  task automatic test_csr_forms;
    issue_one(64'h700, 32'h300022F3, 64'h1234, 64'h99, 1'b1, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd2 || o_wdata !== 64'd0 || o_tval !== 64'h300 || n_wb !== 1 || o_rd !== 5'd5 || o_wdat !== 64'h99) begin n_bad++; $display("FAIL csrrs_x0: op=%0d wdata=%h tval=%h wb=%0d rd=%0d d=%h want 2/0/300/1/5/99", o_op, o_wdata, o_tval, n_wb, o_rd, o_wdat); end
    issue_one(64'h700, 32'h3014B273, 64'hF0, 64'h0, 1'b0, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd3 || o_wdata !== 64'hF0 || o_tval !== 64'h301 || n_wb !== 0 || rd_cyc !== 0 || o_rpc !== 64'h704) begin n_bad++; $display("FAIL csrrc: op=%0d wdata=%h tval=%h wb=%0d cyc=%0d rpc=%h want 3/f0/301/0/0/704", o_op, o_wdata, o_tval, n_wb, rd_cyc, o_rpc); end
    issue_one(64'h700, 32'h30031073, 64'h77, 64'h55, 1'b1, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd1 || o_wdata !== 64'h77 || n_wb !== 0 || n_rd !== 1) begin n_bad++; $display("FAIL csrrw_rd0: op=%0d wdata=%h wb=%0d rd=%0d want 1/77/0/1", o_op, o_wdata, n_wb, n_rd); end
  endtask

  task automatic test_csr_imm;
`ifdef CSR_IMM_EN
    issue_one(64'hA00, 32'h1053D0F3, 64'hFFFF, 64'h55, 1'b1, 1'b0, 64'h0);
    n_cmp++; if (o_op !== 5'd1 || o_tval !== 64'h105 || o_wdata !== 64'd7) begin n_bad++; $display("FAIL csrrwi_issue: op=%0d tval=%h wdata=%h want 1/105/7", o_op, o_tval, o_wdata); end
    n_cmp++; if (n_wb !== 1 || o_rd !== 5'd1 || o_wdat !== 64'h55 || o_rpc !== 64'hA04) begin n_bad++; $display("FAIL csrrwi_wb: n=%0d rd=%0d d=%h rpc=%h want 1/1/55/a04", n_wb, o_rd, o_wdat, o_rpc); end
`else
    issue_one(64'hA00, 32'h1053D0F3, 64'hFFFF, 64'h0, 1'b0, 1'b1, 64'hC00);
    n_cmp++; if (o_op !== 5'd18 || o_tval !== 64'h1053D0F3 || o_wdata !== 64'd0) begin n_bad++; $display("FAIL csrrwi_illegal: op=%0d tval=%h wdata=%h want 18/1053d0f3/0", o_op, o_tval, o_wdata); end
    n_cmp++; if (n_wb !== 0 || o_rpc !== 64'hC00) begin n_bad++; $display("FAIL csrrwi_redir: wb=%0d rpc=%h want 0/c00", n_wb, o_rpc); end
`endif
  endtask

  task automatic test_satp;
    issue_one(64'h2000, 32'h180391F3, 64'h8000_0000_0000_1234, 64'h77, 1'b1, 1'b1, 64'h2004);
    n_cmp++; if (o_op !== 5'd1 || o_tval !== 64'h180 || o_wdata !== 64'h8000_0000_0000_1234) begin n_bad++; $display("FAIL satp_issue: op=%0d tval=%h wdata=%h want 1/180/8000000000001234", o_op, o_tval, o_wdata); end
    n_cmp++; if (n_wb !== 1 || o_rd !== 5'd3 || o_wdat !== 64'h77 || n_rd !== 1 || rd_cyc !== 1 || o_rpc !== 64'h2004) begin n_bad++; $display("FAIL satp_wb_redir: wb=%0d rd=%0d d=%h n=%0d cyc=%0d rpc=%h want 1/3/77/1/1/2004", n_wb, o_rd, o_wdat, n_rd, rd_cyc, o_rpc); end
  endtask

  task automatic test_back_to_back;
    int issues, wbs, runs, bad_runs, run, cyc;
    issues = 0; wbs = 0; runs = 0; bad_runs = 0; run = 0; cyc = 0;
    in_valid = 1'b1; in_pc = 64'hB000; in_insn = 32'h3000A073; in_rs1_val = 64'h3;
    csr_r_valid = 1'b1; csr_rdata = 64'h1111;
    while (cyc < 100 && !(issues == 10 && runs == 10)) begin
      @(negedge clk);
      cyc++;
      if (csr_op !== 5'd0) begin issues++; if (issues == 10) in_valid = 1'b0; end
      if (wb_valid) wbs++;
      if (!in_ready) run++;
      else if (run > 0) begin runs++; if (run != 2) bad_runs++; run = 0; end
    end
    csr_r_valid = 1'b0; csr_rdata = '0; in_valid = 1'b0;
    n_cmp++; if (cyc >= 100) begin n_bad++; $display("FAIL b2b_timeout: cycles=%0d limit 100", cyc); end
    n_cmp++; if (issues !== 10 || wbs !== 0) begin n_bad++; $display("FAIL b2b_counts: issues=%0d wb=%0d want 10/0", issues, wbs); end
    n_cmp++; if (runs !== 10 || bad_runs !== 0) begin n_bad++; $display("FAIL b2b_ready: runs=%0d bad=%0d want 10/0", runs, bad_runs); end
  endtask

  task automatic test_reset_mid;
    int late_rd;
    late_rd = 0;
    in_valid = 1'b1; in_pc = 64'hD000; in_insn = 32'h300312F3; in_rs1_val = 64'h1;
    @(negedge clk);
    in_valid = 1'b0;
    csr_rdata = 64'hABCD; csr_r_valid = 1'b1; csr_trap_en = 1'b1; csr_trap_pc = 64'hE000;
    @(negedge clk);
    csr_r_valid = 1'b0; csr_trap_en = 1'b0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'hABCD) begin n_bad++; $display("FAIL rstmid_in_wb: wb=%b d=%h want 1/abcd", wb_valid, wb_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0 || wb_data !== 64'd0 || csr_pc !== 64'd0) begin n_bad++; $display("FAIL rstmid_async: wb=%b rd=%b busy=%b d=%h pc=%h want 0", wb_valid, redirect_valid, busy, wb_data, csr_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (redirect_valid) late_rd++;
    end
    n_cmp++; if (late_rd !== 0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_dropped: redirects=%0d ready=%b want 0/1", late_rd, in_ready); end
  endtask

  initial begin
    test_reset;
    test_csrrw;
    test_ecall;
    test_system_misc;
    test_illegal;
    test_csr_forms;
    test_csr_imm;
    test_satp;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
